// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, constants,
// FSM state encoding and the word-alignment helper.
package fetch_stage_pkg;

   localparam int WIDTH_32 = 32;

   // MIPS "sll $0,$0,0": the bubble placed in the F/D register when no
   // fetched instruction is ready.
   localparam logic [WIDTH_32-1:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [WIDTH_32-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,   // request presented, waiting for grant
      S_WAIT  = 2'd1,   // granted, waiting for response data
      S_DROP  = 2'd2,   // granted, response must be thrown away (redirected)
      S_VALID = 2'd3    // instruction buffered and offered to decode
   } fetch_state_e;

   // Instruction addresses are word aligned; low two bits are forced clear.
   function automatic logic [WIDTH_32-1:0] align_word(input logic [WIDTH_32-1:0] addr);
      return {addr[WIDTH_32-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus. The fetch stage is the master,
// the instruction memory the slave. At most one request is outstanding.
interface fetch_stage_if;
   import fetch_stage_pkg::*;

   logic                IMEM_REQ;
   logic [WIDTH_32-1:0] IMEM_ADDR;
   logic                IMEM_GNT;
   logic                IMEM_RVALID;
   logic [WIDTH_32-1:0] IMEM_RDATA;

   modport master (
      output IMEM_REQ, IMEM_ADDR,
      input  IMEM_GNT, IMEM_RVALID, IMEM_RDATA
   );

   modport slave (
      input  IMEM_REQ, IMEM_ADDR,
      output IMEM_GNT, IMEM_RVALID, IMEM_RDATA
   );

endinterface

// File: rtl/fetch_stage_next_pc_sel.sv
// Redirect detection and target selection for control transfers resolved in
// Decode. A taken branch wins over a simultaneous jump.
module fetch_stage_next_pc_sel
   import fetch_stage_pkg::*;
(
   input  logic                branch_taken,
   input  logic [WIDTH_32-1:0] branch_target,
   input  logic                jump,
   input  logic [WIDTH_32-1:0] jump_target,
   output logic                redirect,
   output logic [WIDTH_32-1:0] target
);

   assign redirect = branch_taken | jump;

   // Pick the redirect target and drop the byte-offset bits.
   always_comb begin
      target = align_word(branch_taken ? branch_target : jump_target);
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory request
// at a time, buffers the returned instruction and offers it (or a NOP bubble)
// to the Fetch/Decode register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [WIDTH_32-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                STALL_F,
   input  logic                BRANCH_TAKEN_D,
   input  logic [WIDTH_32-1:0] BRANCH_TARGET_D,
   input  logic                JUMP_D,
   input  logic [WIDTH_32-1:0] JUMP_TARGET_D,
   fetch_stage_if.master       imem,
   output logic [WIDTH_32-1:0] INSTRUCTION_F,
   output logic [WIDTH_32-1:0] PC_plus_4_F,
   output logic                FETCH_VALID
);

   fetch_state_e        state_q, state_d;
   logic [WIDTH_32-1:0] pc_q, pc_d;
   logic [WIDTH_32-1:0] buf_q, buf_d;
   logic                redirect;
   logic [WIDTH_32-1:0] target;

   fetch_stage_next_pc_sel u_next_pc_sel (
      .branch_taken  (BRANCH_TAKEN_D),
      .branch_target (BRANCH_TARGET_D),
      .jump          (JUMP_D),
      .jump_target   (JUMP_TARGET_D),
      .redirect      (redirect),
      .target        (target)
   );

   // State, PC and instruction buffer registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (rst) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         buf_q   <= buf_d;
      end
   end

   // Next-state, next-PC and buffer-load decisions of the fetch handshake.
   always_comb begin
      // NOTE: hold-value defaults first, so no path leaves a signal unassigned
      // and no latch is inferred.
      state_d = state_q;
      pc_d    = pc_q;
      buf_d   = buf_q;

      unique case (state_q)
         S_REQ: begin
            if (redirect) begin
               pc_d = target;
            end
            if (imem.IMEM_GNT) begin
               state_d = redirect ? S_DROP : S_WAIT;
            end
         end

         S_WAIT: begin
            if (imem.IMEM_RVALID) begin
               if (redirect) begin
                  pc_d    = target;
                  state_d = S_REQ;
               end else begin
                  buf_d   = imem.IMEM_RDATA;
                  state_d = S_VALID;
               end
            end else if (redirect) begin
               pc_d    = target;
               state_d = S_DROP;
            end
         end

         // The in-flight response belongs to a squashed path; absorb it.
         S_DROP: begin
            if (redirect) begin
               pc_d = target;
            end
            if (imem.IMEM_RVALID) begin
               state_d = S_REQ;
            end
         end

         // A redirect beats a stall: the buffered instruction is on a dead path.
         S_VALID: begin
            if (redirect) begin
               pc_d    = target;
               state_d = S_REQ;
            end else if (!STALL_F) begin
               pc_d    = pc_q + 32'd4;
               state_d = S_REQ;
            end
         end

         default: state_d = S_REQ;
      endcase
   end

   // Bus and F/D-facing outputs, all decoded from registered state.
   always_comb begin
      imem.IMEM_REQ  = (state_q == S_REQ) && !rst;
      imem.IMEM_ADDR = pc_q;
      PC_plus_4_F    = pc_q + 32'd4;
      FETCH_VALID    = (state_q == S_VALID);
      INSTRUCTION_F  = FETCH_VALID ? buf_q : NOP_INSTR;
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized traffic
// against a behavioural model. Fetched instructions go through a scoreboard
// queue that an independent monitor drains whenever FETCH_VALID rises.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main DUT (RESET_PC = 0)
   logic        rst = 1'b1, stall = 1'b0, br = 1'b0, jmp = 1'b0;
   logic [31:0] bt = '0, jt = '0;
   logic [31:0] instr, pc4;
   logic        fv;
   fetch_stage_if bus ();

   fetch_stage dut (
      .clk             (clk),
      .rst             (rst),
      .STALL_F         (stall),
      .BRANCH_TAKEN_D  (br),
      .BRANCH_TARGET_D (bt),
      .JUMP_D          (jmp),
      .JUMP_TARGET_D   (jt),
      .imem            (bus),
      .INSTRUCTION_F   (instr),
      .PC_plus_4_F     (pc4),
      .FETCH_VALID     (fv)
   );

   // Second DUT for the address wrap-around case
   logic        rst_w = 1'b1, stall_w = 1'b0;
   logic [31:0] instr_w, pc4_w;
   logic        fv_w;
   fetch_stage_if bus_w ();

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk             (clk),
      .rst             (rst_w),
      .STALL_F         (stall_w),
      .BRANCH_TAKEN_D  (1'b0),
      .BRANCH_TARGET_D (32'h0),
      .JUMP_D          (1'b0),
      .JUMP_TARGET_D   (32'h0),
      .imem            (bus_w),
      .INSTRUCTION_F   (instr_w),
      .PC_plus_4_F     (pc4_w),
      .FETCH_VALID     (fv_w)
   );

   initial begin
      bus.IMEM_GNT      = 1'b0;
      bus.IMEM_RVALID   = 1'b0;
      bus.IMEM_RDATA    = '0;
      bus_w.IMEM_GNT    = 1'b0;
      bus_w.IMEM_RVALID = 1'b0;
      bus_w.IMEM_RDATA  = '0;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst, stall, br, jmp, gnt, rvalid;
      logic [31:0] bt, jt, rdata;
   } stim_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   exp_t sb[$];

   // Behavioural model: PC, whether a granted request awaits its response,
   // whether that response is already known to be unwanted, and whether an
   // instruction is being held for decode.
   logic [31:0] m_pc = '0, m_instr = '0;
   bit          m_busy = 0, m_discard = 0, m_have = 0, m_rst = 1;

   function automatic stim_t idle();
      stim_t s;
      s.rst = 0; s.stall = 0; s.br = 0; s.jmp = 0; s.gnt = 0; s.rvalid = 0;
      s.bt = '0; s.jt = '0; s.rdata = '0;
      return s;
   endfunction

   function automatic bit model_req(input bit r);
      return !r && !m_busy && !m_have;
   endfunction

   // Wait to the falling edge and compare every DUT output to the model.
   task automatic settle();
      @(negedge clk);
      check("imem_req",  {31'd0, bus.IMEM_REQ}, {31'd0, model_req(m_rst)});
      check("imem_addr", bus.IMEM_ADDR, m_pc);
      check("pc_plus_4", pc4, m_pc + 32'd4);
      check("fetch_valid", {31'd0, fv}, {31'd0, m_have});
      check("instruction", instr, m_have ? m_instr : NOP_INSTR);
   endtask

   // Apply one cycle of stimulus and advance the model to the next edge.
   task automatic drive(input stim_t s);
      logic        redir;
      logic [31:0] tgt;
      rst = s.rst; stall = s.stall; br = s.br; bt = s.bt; jmp = s.jmp; jt = s.jt;
      bus.IMEM_GNT = s.gnt; bus.IMEM_RVALID = s.rvalid; bus.IMEM_RDATA = s.rdata;

      redir = s.br || s.jmp;
      tgt   = (s.br ? s.bt : s.jt) & 32'hFFFF_FFFC;
      if (s.rst) begin
         m_pc = 32'h0; m_busy = 0; m_discard = 0; m_have = 0; m_instr = '0;
      end else if (m_have) begin
         if (redir) begin
            m_pc = tgt; m_have = 0;
         end else if (!s.stall) begin
            m_pc = m_pc + 32'd4; m_have = 0;
         end
      end else if (!m_busy) begin
         if (s.gnt) begin
            m_busy = 1; m_discard = redir;
         end
         if (redir) m_pc = tgt;
      end else begin
         if (s.rvalid) begin
            m_busy = 0;
            if (!m_discard && !redir) begin
               m_have  = 1;
               m_instr = s.rdata;
               sb.push_back('{instr: s.rdata, pc4: m_pc + 32'd4});
            end
         end else if (redir) begin
            m_discard = 1;
         end
         if (redir) m_pc = tgt;
      end
      m_rst = s.rst;
   endtask

   // Monitor: each new FETCH_VALID episode must match the oldest expectation.
   initial begin
      bit   prev;
      exp_t e;
      prev = 0;
      forever begin
         @(posedge clk);
         #1;
         if (fv && !prev) begin
            check("sb_pending", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("sb_instr", instr, e.instr);
               check("sb_pc4", pc4, e.pc4);
            end
         end
         prev = fv;
      end
   end

   initial begin
      stim_t s;
      bit    mem_busy;
      int    mem_lat;
      bit    req_now;

      // Reset, then zero-wait memory
      s = idle(); s.rst = 1; drive(s);
      settle();
      check("rst_req", {31'd0, bus.IMEM_REQ}, 32'd0);
      check("rst_instr", instr, NOP_INSTR);
      s = idle(); s.gnt = 1; drive(s);
      settle();
      s = idle(); s.rvalid = 1; s.rdata = 32'h2008_0005; drive(s);
      settle();
      check("zw_valid", {31'd0, fv}, 32'd1);
      check("zw_instr", instr, 32'h2008_0005);
      check("zw_pc4", pc4, 32'h4);

      // Stall hold for three cycles
      for (int i = 0; i < 3; i++) begin
         s = idle(); s.stall = 1; drive(s);
         settle();
         check("stall_instr", instr, 32'h2008_0005);
         check("stall_addr", bus.IMEM_ADDR, 32'h0);
         check("stall_req", {31'd0, bus.IMEM_REQ}, 32'd0);
      end
      s = idle(); drive(s);
      settle();
      check("unstall_addr", bus.IMEM_ADDR, 32'h4);
      check("unstall_req", {31'd0, bus.IMEM_REQ}, 32'd1);

      // Redirect while waiting for the response
      s = idle(); s.jmp = 1; s.jt = 32'h10; drive(s);
      settle();
      check("jmp_addr", bus.IMEM_ADDR, 32'h10);
      s = idle(); s.gnt = 1; drive(s);
      settle();
      s = idle(); s.br = 1; s.bt = 32'h43; drive(s);
      settle();
      check("drop_req", {31'd0, bus.IMEM_REQ}, 32'd0);
      s = idle(); s.rvalid = 1; s.rdata = 32'hBAD0_0BAD; drive(s);
      settle();
      check("drop_valid", {31'd0, fv}, 32'd0);
      check("drop_next_addr", bus.IMEM_ADDR, 32'h40);
      check("drop_next_req", {31'd0, bus.IMEM_REQ}, 32'd1);

      // Branch and jump together while stalled in the valid state
      s = idle(); s.gnt = 1; drive(s);
      settle();
      s = idle(); s.rvalid = 1; s.rdata = 32'h0000_1234; drive(s);
      settle();
      check("bj_pre_valid", {31'd0, fv}, 32'd1);
      s = idle(); s.stall = 1; s.br = 1; s.bt = 32'h100; s.jmp = 1; s.jt = 32'h200; drive(s);
      settle();
      check("bj_addr", bus.IMEM_ADDR, 32'h100);
      check("bj_valid", {31'd0, fv}, 32'd0);

      // Reset while waiting, stale response after release
      s = idle(); s.gnt = 1; drive(s);
      settle();
      s = idle(); s.rst = 1; drive(s);
      settle();
      s = idle(); s.rvalid = 1; s.rdata = 32'hDEAD_BEEF; drive(s);
      settle();
      check("stale_valid", {31'd0, fv}, 32'd0);
      check("stale_req", {31'd0, bus.IMEM_REQ}, 32'd1);
      check("stale_addr", bus.IMEM_ADDR, 32'h0);
      s = idle(); drive(s);
      settle();
      check("stale_valid2", {31'd0, fv}, 32'd0);

      // Wrap-around on the second instance
      check("wrap_pc4", pc4_w, 32'h0);
      check("wrap_addr", bus_w.IMEM_ADDR, 32'hFFFF_FFFC);
      s = idle(); drive(s);
      rst_w = 1'b0; bus_w.IMEM_GNT = 1'b1;
      settle();
      s = idle(); drive(s);
      bus_w.IMEM_GNT = 1'b0; bus_w.IMEM_RVALID = 1'b1; bus_w.IMEM_RDATA = 32'h0000_0013;
      settle();
      check("wrap_valid", {31'd0, fv_w}, 32'd1);
      check("wrap_instr", instr_w, 32'h0000_0013);
      check("wrap_pc4_v", pc4_w, 32'h0);
      s = idle(); drive(s);
      bus_w.IMEM_RVALID = 1'b0; stall_w = 1'b0;
      settle();
      check("wrap_next_addr", bus_w.IMEM_ADDR, 32'h0);
      check("wrap_next_req", {31'd0, bus_w.IMEM_REQ}, 32'd1);
      rst_w = 1'b1;

      // Randomized traffic with a variable-latency memory
      s = idle(); s.rst = 1; drive(s);
      mem_busy = 0; mem_lat = 0;
      for (int n = 0; n < 3000; n++) begin
         settle();
         s = idle();
         s.rst   = ($urandom_range(0, 199) == 0);
         s.stall = ($urandom_range(0, 2) == 0);
         s.br    = ($urandom_range(0, 7) == 0);
         s.bt    = $urandom;
         s.jmp   = ($urandom_range(0, 7) == 0);
         s.jt    = $urandom;
         s.gnt   = $urandom_range(0, 1);
         s.rdata = $urandom;
         if (mem_busy) begin
            if (mem_lat == 0) s.rvalid = 1;
            else mem_lat--;
         end
         req_now = model_req(s.rst);
         drive(s);
         if (s.rvalid) mem_busy = 0;
         if (req_now && s.gnt) begin
            mem_busy = 1;
            mem_lat  = $urandom_range(0, 3);
         end
         if (s.rst) mem_busy = 0;
      end

      // Drain: let any outstanding response complete, no new grants
      for (int n = 0; n < 8; n++) begin
         settle();
         s = idle();
         if (mem_busy) begin
            if (mem_lat == 0) s.rvalid = 1;
            else mem_lat--;
         end
         drive(s);
         if (s.rvalid) mem_busy = 0;
      end
      settle();
      check("sb_drained", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the Fetch/Decode pipeline register.
- Owns the PC register and next-PC selection (sequential, branch, jump).
- Runs a single-outstanding request/response handshake with instruction memory.
- Presents INSTRUCTION_F / PC_plus_4_F to the F/D register and inserts a NOP bubble (32'd0) whenever no fetched instruction is ready.

Parameters:
- WIDTH_32, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction emitted when FETCH_VALID=0 (MIPS sll $0,$0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- STALL_F  in  1  hazard unit stall; F/D register not enabled this cycle.
- BRANCH_TAKEN_D  in  1  branch resolved taken in Decode.
- BRANCH_TARGET_D  in  32  branch target.
- JUMP_D  in  1  jump in Decode.
- JUMP_TARGET_D  in  32  jump target.
- IMEM_REQ  out  1  fetch request valid.
- IMEM_ADDR  out  32  fetch address (= PC).
- IMEM_GNT  in  1  memory accepts request this cycle.
- IMEM_RVALID  in  1  response data valid.
- IMEM_RDATA  in  32  response instruction.
- INSTRUCTION_F  out  32  instruction to F/D register.
- PC_plus_4_F  out  32  PC+4 to F/D register.
- FETCH_VALID  out  1  INSTRUCTION_F holds a real fetched instruction.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Redirect definition:
  - REDIRECT = BRANCH_TAKEN_D | JUMP_D.
  - Target = BRANCH_TARGET_D if BRANCH_TAKEN_D, else JUMP_TARGET_D (branch wins if both are asserted).
  - Target bits [1:0] are forced to 0 when loaded into PC.
- PC_plus_4_F = PC + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0); combinational from PC.
- IMEM_ADDR = PC at all times.
- On rst (any state, including a request outstanding):
  - PC <= RESET_PC, state <= S_REQ, instruction buffer <= 0.
  - IMEM_REQ = 0 while rst is high.
  - FETCH_VALID = 0, INSTRUCTION_F = NOP_INSTR.
  - A stale IMEM_RVALID arriving after reset is ignored, because S_REQ ignores RVALID.
- Output rules:
  - IMEM_REQ = 1 only in S_REQ.
  - FETCH_VALID = 1 only in S_VALID.
  - INSTRUCTION_F = buffer in S_VALID, NOP_INSTR otherwise.
- FSM (one state register, 2 bits):
  - S_REQ:
    - GNT & !REDIRECT -> S_WAIT.
    - GNT & REDIRECT -> PC <= target, -> S_DROP.
    - !GNT & REDIRECT -> PC <= target, stay in S_REQ.
    - !GNT -> stay in S_REQ.
  - S_WAIT:
    - RVALID & !REDIRECT -> buffer <= RDATA, -> S_VALID.
    - RVALID & REDIRECT -> discard data, PC <= target, -> S_REQ.
    - !RVALID & REDIRECT -> PC <= target, -> S_DROP.
    - Otherwise stay in S_WAIT.
  - S_DROP:
    - Wait for the in-flight response; RVALID -> discard, -> S_REQ.
    - REDIRECT in S_DROP updates PC, stays in S_DROP until RVALID.
  - S_VALID:
    - REDIRECT -> PC <= target, -> S_REQ (REDIRECT has priority over STALL_F).
    - else !STALL_F -> PC <= PC+4, -> S_REQ.
    - else (stalled) hold buffer, PC and state.
- At most one request outstanding; RVALID may arrive 1..N cycles after GNT.
- Minimum latency: request to FETCH_VALID = 2 cycles (GNT cycle, then RVALID cycle, valid on the next cycle).
- Peak throughput: one instruction per 3 cycles. Accepted for this pre-branch-prediction build.
- Bubbles: while FETCH_VALID=0 and STALL_F=0, the F/D register latches NOP_INSTR, which is a legal bubble.

Decomposition:
- Shared pipeline package holds: state encoding (S_REQ=0, S_WAIT=1, S_DROP=2, S_VALID=3), NOP_INSTR constant, RESET_PC default.
- One natural sub-module: next_pc_sel (combinational target mux plus 2-bit alignment).
- The PC register, FSM and buffer stay in fetch_stage.

Test Plan:
- Reset then zero-wait memory: GNT=1 in the request cycle, RVALID=1 the next cycle, RDATA=0x2008_0005.
  - Required: FETCH_VALID=1 and INSTRUCTION_F=0x2008_0005 with PC_plus_4_F=0x4; next IMEM_ADDR=0x4.
- Stall hold: in S_VALID hold STALL_F=1 for 3 cycles.
  - Required: INSTRUCTION_F, PC and FETCH_VALID unchanged; IMEM_REQ=0.
  - Then STALL_F=0: IMEM_ADDR advances by 4.
- Redirect while waiting: PC=0x10, GNT given, then BRANCH_TAKEN_D=1 with target 0x43 before RVALID.
  - Required: state S_DROP; the next RVALID data is discarded (FETCH_VALID stays 0).
  - Required: the following request has IMEM_ADDR=0x40.
- Simultaneous BRANCH_TAKEN_D and JUMP_D (targets 0x100 and 0x200) in S_VALID with STALL_F=1.
  - Required: PC=0x100; the redirect overrides the stall.
- Wrap-around: RESET_PC=0xFFFF_FFFC.
  - Required: PC_plus_4_F=0x0; after consuming the instruction, IMEM_ADDR=0x0.
- Reset mid-operation: assert rst in S_WAIT, then deliver RVALID with 0xDEAD_BEEF the cycle after reset is released.
  - Required: data ignored, FETCH_VALID=0, IMEM_REQ=1 with IMEM_ADDR=RESET_PC.
